// File: rtl/csr_trap_if.sv
// Pipeline <-> CSR/trap unit bus.
//   master : execute-stage side (drives CSR access, mret, pc, stall; receives
//            read data and the redirect request)
//   slave  : csr_trap_unit side
interface csr_trap_if;
    logic        stall;
    logic        csr_reg_r;
    logic        csr_reg_wr;
    logic        is_mret;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] pc;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc;

    modport master (
        output stall,
        output csr_reg_r,
        output csr_reg_wr,
        output is_mret,
        output csr_addr,
        output csr_wdata,
        output pc,
        input  csr_rdata,
        input  epc_taken,
        input  epc
    );

    modport slave (
        input  stall,
        input  csr_reg_r,
        input  csr_reg_wr,
        input  is_mret,
        input  csr_addr,
        input  csr_wdata,
        input  pc,
        output csr_rdata,
        output epc_taken,
        output epc
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap responder.
// Executes CSRRW (old value returned combinationally on csr_rdata), samples the
// timer and external interrupts through a synchronizer, and raises a redirect
// (epc_taken/epc) for trap entry or MRET in the same cycle.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   timer_intr        level timer interrupt, asynchronous to clk
//   ext_intr          level external interrupt, asynchronous to clk
//   bus (slave)       stall, csr_reg_r, csr_reg_wr, is_mret, csr_addr,
//                     csr_wdata, pc in; csr_rdata, epc_taken, epc out
module csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_intr,
    input  logic        ext_intr,
    csr_trap_if.slave   bus
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [3:0]  CAUSE_TIMER  = 4'd7;
    localparam logic [3:0]  CAUSE_EXT    = 4'd11;
    localparam logic [1:0]  MODE_VECTOR  = 2'b01;

    // Architectural state
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_mtie;
    logic        mie_meie;
    logic [31:0] mtvec_q;
    logic [31:2] mepc_q;
    logic [31:0] mcause_q;

    // Interrupt synchronizers
    logic [SYNC_STAGES-1:0] timer_sync;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   mip_mtip;
    logic                   mip_meip;

    // Combinational decode
    logic        pend_timer;
    logic        pend_ext;
    logic        trap_c;
    logic        mret_c;
    logic        wr_en;
    logic [3:0]  cause_c;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic [31:0] rd_val;

    // Double/triple-flop synchronizer on each asynchronous interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_sync <= '0;
            ext_sync   <= '0;
        end else begin
            timer_sync[0] <= timer_intr;
            ext_sync[0]   <= ext_intr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                timer_sync[i] <= timer_sync[i-1];
                ext_sync[i]   <= ext_sync[i-1];
            end
        end
    end

    assign mip_mtip = timer_sync[SYNC_STAGES-1];
    assign mip_meip = ext_sync[SYNC_STAGES-1];

    // Packed views of the sparse CSRs
    assign mstatus_val = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
    assign mie_val     = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
    assign mip_val     = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};

    // Trap / mret qualification; MRET pre-empts a pending interrupt
    assign pend_timer = mstatus_mie & mie_mtie & mip_mtip;
    assign pend_ext   = mstatus_mie & mie_meie & mip_meip;
    assign trap_c     = (pend_timer | pend_ext) & ~bus.stall & ~bus.is_mret;
    assign mret_c     = bus.is_mret & ~bus.stall;
    assign cause_c    = pend_ext ? CAUSE_EXT : CAUSE_TIMER;

    // A trapped instruction is flushed, so its CSR write must not land
    assign wr_en      = bus.csr_reg_wr & ~bus.stall & ~trap_c;

    // Vectored mode offsets the base by 4*cause
    assign trap_base   = {mtvec_q[31:2], 2'b00};
    assign trap_target = (mtvec_q[1:0] == MODE_VECTOR)
                       ? trap_base + {26'd0, cause_c, 2'b00}
                       : trap_base;

    // CSR read mux (pre-write value)
    always_comb begin
        rd_val = 32'd0;
        unique case (bus.csr_addr)
            ADDR_MSTATUS: rd_val = mstatus_val;
            ADDR_MIE:     rd_val = mie_val;
            ADDR_MTVEC:   rd_val = mtvec_q;
            ADDR_MEPC:    rd_val = {mepc_q, 2'b00};
            ADDR_MCAUSE:  rd_val = mcause_q;
            ADDR_MIP:     rd_val = mip_val;
            default:      rd_val = 32'd0;
        endcase
    end

    // Outputs are gated by rst so a reset mid-trap drops them immediately
    always_comb begin
        bus.csr_rdata = 32'd0;
        bus.epc_taken = 1'b0;
        bus.epc       = 32'd0;
        if (!rst) begin
            if (bus.csr_reg_r) begin
                bus.csr_rdata = rd_val;
            end
            if (trap_c) begin
                bus.epc_taken = 1'b1;
                bus.epc       = trap_target;
            end else if (mret_c) begin
                bus.epc_taken = 1'b1;
                bus.epc       = {mepc_q, 2'b00};
            end
        end
    end

    // CSR state: software writes first, then trap/mret side effects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec_q      <= RESET_MTVEC;
            mepc_q       <= 30'd0;
            mcause_q     <= 32'd0;
        end else begin
            if (wr_en) begin
                unique case (bus.csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= bus.csr_wdata[3];
                        mstatus_mpie <= bus.csr_wdata[7];
                    end
                    ADDR_MIE: begin
                        mie_mtie <= bus.csr_wdata[7];
                        mie_meie <= bus.csr_wdata[11];
                    end
                    ADDR_MTVEC:  mtvec_q  <= bus.csr_wdata;
                    ADDR_MEPC:   mepc_q   <= bus.csr_wdata[31:2];
                    ADDR_MCAUSE: mcause_q <= bus.csr_wdata;
                    default: ;
                endcase
            end
            if (trap_c) begin
                mepc_q       <= bus.pc[31:2];
                mcause_q     <= {1'b1, 27'd0, cause_c};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end
            // Takes precedence over any same-cycle mstatus write
            if (mret_c) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    // Bits that are architecturally ignored
    logic unused_bits;
    assign unused_bits = ^{bus.pc[1:0], bus.csr_wdata[1:0]};

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR read-back, vectored/direct traps,
// interrupt priority, MRET, trap/write collision, stall and async reset.
module tb_csr_trap_unit;

    localparam logic [31:0] RESET_MTVEC = 32'h0000_0000;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_UNMAP   = 12'h7C0;

    logic clk;
    logic rst;
    logic timer_intr;
    logic ext_intr;

    int checks;
    int errors;

    csr_trap_if bus ();

    csr_trap_unit #(
        .RESET_MTVEC (RESET_MTVEC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_intr (timer_intr),
        .ext_intr   (ext_intr),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs then change 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        bus.csr_addr   = addr;
        bus.csr_wdata  = data;
        bus.csr_reg_wr = 1'b1;
        tick();
        bus.csr_reg_wr = 1'b0;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.csr_addr  = addr;
        bus.csr_reg_r = 1'b1;
        #1;
        check_val(tag, bus.csr_rdata, exp);
        bus.csr_reg_r = 1'b0;
    endtask

    task automatic check_redirect(input string tag, input logic taken, input logic [31:0] target);
        #1;
        check_val({tag, "_taken"}, 32'(bus.epc_taken), 32'(taken));
        check_val({tag, "_epc"}, bus.epc, target);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        timer_intr   = 1'b0;
        ext_intr     = 1'b0;
        bus.stall      = 1'b0;
        bus.csr_reg_r  = 1'b0;
        bus.csr_reg_wr = 1'b0;
        bus.is_mret    = 1'b0;
        bus.csr_addr   = 12'h000;
        bus.csr_wdata  = 32'd0;
        bus.pc         = 32'd0;

        // Reset state
        tick();
        tick();
        bus.csr_reg_r = 1'b1;
        bus.csr_addr  = A_MTVEC;
        #1;
        check_val("rst_rdata", bus.csr_rdata, 32'd0);
        bus.csr_reg_r = 1'b0;
        check_redirect("rst", 1'b0, 32'd0);
        rst = 1'b0;
        csr_read("rst_mtvec", A_MTVEC, RESET_MTVEC);
        csr_read("rst_mstatus", A_MSTATUS, 32'd0);
        csr_read("rst_mcause", A_MCAUSE, 32'd0);

        // Read-back, masking, unmapped and read-only
        csr_write(A_MTVEC, 32'h0000_0101);
        csr_write(A_MIE, 32'h0000_0888);
        csr_read("mie_mask", A_MIE, 32'h0000_0880);
        bus.csr_reg_r = 1'b1;
        bus.csr_reg_wr = 1'b1;
        bus.csr_addr  = A_MTVEC;
        bus.csr_wdata = 32'h1234_5678;
        #1;
        check_val("csrrw_old", bus.csr_rdata, 32'h0000_0101);
        tick();
        bus.csr_reg_r = 1'b0;
        bus.csr_reg_wr = 1'b0;
        csr_read("csrrw_new", A_MTVEC, 32'h1234_5678);
        csr_write(A_UNMAP, 32'hFFFF_FFFF);
        csr_read("unmapped", A_UNMAP, 32'd0);
        csr_write(A_MIP, 32'hFFFF_FFFF);
        csr_read("mip_ro", A_MIP, 32'd0);
        csr_write(A_MSTATUS, 32'hFFFF_FFFF);
        csr_read("mstatus_mask", A_MSTATUS, 32'h0000_0088);
        csr_write(A_MSTATUS, 32'h0000_0000);

        // Vectored timer trap: 0x100 + 4*7 = 0x11C
        csr_write(A_MTVEC, 32'h0000_0101);
        csr_write(A_MIE, 32'h0000_0080);
        bus.pc = 32'h0000_0040;
        csr_write(A_MSTATUS, 32'h0000_0008);
        timer_intr = 1'b1;
        check_redirect("sync0", 1'b0, 32'd0);
        tick();
        check_redirect("sync1", 1'b0, 32'd0);
        tick();
        check_redirect("vec_trap", 1'b1, 32'h0000_011C);
        csr_read("mip_timer", A_MIP, 32'h0000_0080);
        tick();
        check_redirect("post_trap", 1'b0, 32'd0);
        csr_read("vec_mepc", A_MEPC, 32'h0000_0040);
        csr_read("vec_mcause", A_MCAUSE, 32'h8000_0007);
        csr_read("vec_mstatus", A_MSTATUS, 32'h0000_0080);

        // MRET, then re-trap while the timer is still high
        bus.is_mret = 1'b1;
        check_redirect("mret", 1'b1, 32'h0000_0040);
        tick();
        bus.is_mret = 1'b0;
        csr_read("mret_mstatus", A_MSTATUS, 32'h0000_0088);
        check_redirect("retrap", 1'b1, 32'h0000_011C);
        tick();
        csr_read("retrap_mstatus", A_MSTATUS, 32'h0000_0080);

        // Priority: external over timer, direct mode
        bus.pc = 32'h0000_0080;
        csr_write(A_MIE, 32'h0000_0880);
        csr_write(A_MTVEC, 32'h0000_0200);
        ext_intr = 1'b1;
        tick();
        tick();
        csr_write(A_MSTATUS, 32'h0000_0008);
        check_redirect("prio", 1'b1, 32'h0000_0200);
        tick();
        csr_read("prio_mcause", A_MCAUSE, 32'h8000_000B);
        csr_read("prio_mepc", A_MEPC, 32'h0000_0080);

        // Trap vs CSR write collision
        csr_write(A_MSTATUS, 32'h0000_0008);
        bus.pc         = 32'h0000_0124;
        bus.csr_addr   = A_MEPC;
        bus.csr_wdata  = 32'hDEAD_BEE0;
        bus.csr_reg_r  = 1'b1;
        bus.csr_reg_wr = 1'b1;
        #1;
        check_val("coll_old", bus.csr_rdata, 32'h0000_0080);
        check_val("coll_taken", 32'(bus.epc_taken), 32'd1);
        tick();
        bus.csr_reg_r  = 1'b0;
        bus.csr_reg_wr = 1'b0;
        csr_read("coll_mepc", A_MEPC, 32'h0000_0124);

        // Stall blocks trap and writes, reads still work
        csr_write(A_MSTATUS, 32'h0000_0008);
        bus.stall = 1'b1;
        check_redirect("stall", 1'b0, 32'd0);
        bus.pc         = 32'h0000_0300;
        bus.csr_addr   = A_MEPC;
        bus.csr_wdata  = 32'h0000_0055;
        bus.csr_reg_wr = 1'b1;
        tick();
        bus.csr_reg_wr = 1'b0;
        csr_read("stall_mepc", A_MEPC, 32'h0000_0124);
        csr_read("stall_mstatus", A_MSTATUS, 32'h0000_0008);
        bus.stall = 1'b0;
        check_redirect("unstall", 1'b1, 32'h0000_0200);
        tick();
        csr_read("unstall_mepc", A_MEPC, 32'h0000_0300);

        // Async reset during an MRET redirect
        bus.is_mret = 1'b1;
        check_redirect("mret2", 1'b1, 32'h0000_0300);
        #2;
        rst = 1'b1;
        check_redirect("async_rst", 1'b0, 32'd0);
        bus.is_mret = 1'b0;
        timer_intr  = 1'b0;
        ext_intr    = 1'b0;
        tick();
        rst = 1'b0;
        csr_read("post_rst_mtvec", A_MTVEC, RESET_MTVEC);
        csr_read("post_rst_mepc", A_MEPC, 32'd0);
        csr_read("post_rst_mcause", A_MCAUSE, 32'd0);
        csr_read("post_rst_mie", A_MIE, 32'd0);
        csr_read("post_rst_mstatus", A_MSTATUS, 32'd0);
        csr_read("post_rst_mip", A_MIP, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Machine-mode CSR file and trap responder for the three-stage pipeline. It consumes the pipelined csr_reg_r / csr_reg_wr / is_mret control bits from the decode stage and executes CSRRW. It samples timer and external interrupts and supplies the PC redirect target plus the flush request back to the fetch path.

Parameters:
RESET_MTVEC, 32'h0000_0000, reset value of mtvec.
SYNC_STAGES, 2, flip-flop synchronizer depth on each interrupt input (1..3).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  pipeline stall; blocks trap entry and all CSR/mret state updates
csr_reg_r  input  1  CSR read enable (CSRRW in execute stage)
csr_reg_wr  input  1  CSR write enable (CSRRW in execute stage)
is_mret  input  1  MRET in execute stage
csr_addr  input  12  CSR address, instruction[31:20]
csr_wdata  input  32  rs1 value to write
pc  input  32  PC of the instruction in execute stage
timer_intr  input  1  level timer interrupt, asynchronous to clk
ext_intr  input  1  level external interrupt, asynchronous to clk
csr_rdata  output  32  old CSR value for writeback (wb_sel=2'b11)
epc_taken  output  1  redirect request; the pipeline flushes and loads epc
epc  output  32  redirect target

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7; all other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11.
  - mtvec 0x305: BASE [31:2], MODE [1:0]; MODE=1 means vectored, any other value means direct.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only. MTIP bit7 and MEIP bit11 are the synchronized inputs.
  - Any other address reads 0; writes to it are ignored.
- Reset (async): mstatus, mie, mepc, mcause all 0; mtvec = RESET_MTVEC; synchronizer flops 0. Outputs: csr_rdata=0, epc_taken=0, epc=0.
- csr_rdata is combinational. When csr_reg_r=1 it shows the current (pre-write) value of csr_addr; otherwise it is 0.
- CSR write: csr_reg_wr=1 and stall=0 and no trap this cycle. The register updates on the next rising edge. Writes to mip or unmapped addresses are ignored.
- Interrupts:
  - pend = mstatus.MIE & (mie & mip).
  - Priority: external (cause 11) over timer (cause 7).
  - Inputs pass SYNC_STAGES flops, so added latency = SYNC_STAGES cycles.
- Trap entry (trap = |pend & !stall & !is_mret), combinational in the same cycle:
  - epc_taken=1.
  - Direct mode: epc = {mtvec[31:2],2'b00}. Vectored mode: epc = {mtvec[31:2],2'b00} + 4*cause.
- Trap entry, at the next clock edge:
  - mepc <= {pc[31:2],2'b00}.
  - mcause <= {1'b1, 27'd0, cause[3:0]}.
  - MPIE <= MIE, MIE <= 0.
  - A CSR write in the same cycle is suppressed. That instruction is flushed and re-executes after return.
- MRET (is_mret=1 and stall=0), combinational in the same cycle: epc_taken=1, epc=mepc.
- MRET, at the next clock edge: MIE <= MPIE, MPIE <= 1.
- MRET and pending interrupt in the same cycle: MRET wins. The interrupt is taken on a later cycle once the restored MIE allows it.
- stall=1: epc_taken=0, epc=0, no state changes. csr_rdata still follows csr_reg_r.
- Idle (no trap, no mret): epc_taken=0, epc=0.
- Interrupts are level-sensitive. They stay pending until the source deasserts; they are not latched.
- rst asserted mid-trap: all state returns to reset values immediately, and epc_taken drops asynchronously.

Test Plan:
- Reset then read-back: write 0x0000_0101 to mtvec, then write 0x888 to mie; then CSRRW 0x12345678 to mtvec -> csr_rdata=0x0000_0101 that cycle, and mtvec=0x12345678 afterwards.
- Vectored timer trap: mtvec=0x0000_0101, mie=0x080, mstatus=0x8, pc=0x40; raise timer_intr -> after 2 cycles epc_taken=1 and epc=0x0000_011C; next cycle mepc=0x40, mcause=0x8000_0007, mstatus=0x80.
- Priority: both interrupts raised, mie=0x880, direct mtvec=0x200 -> epc=0x200, mcause=0x8000_000B.
- MRET after trap: is_mret=1 -> epc_taken=1, epc=0x40; next cycle mstatus=0x88. With timer still high -> re-trap occurs on the cycle after.
- Trap vs CSR write collision: interrupt pending while CSRRW to mepc with 0xDEAD_BEE0 -> mepc=pc of the CSRRW, and the write is dropped.
- Stall and reset: stall=1 with interrupt pending -> epc_taken=0 and no state change; deassert stall -> trap taken. Assert rst mid-stream -> mtvec=RESET_MTVEC and all other CSRs 0.
